mean_square_accumulator_v1_0: RTL

Windowed mean-square engine feeding the RMS square-root stage. It squares each signed input sample and accumulates over a fixed power-of-two window, then divides by the window length with a shift. The mean-square result is handed to the downstream sqrt block as its radicand, using a one-cycle valid pulse.
Its output width is 2*inout_width, so the result connects directly to the radicand port of a sqrt with the same inout_width.

---
 rtl/mean_square_accumulator_v1_0_pkg.sv | 10 +
 rtl/signed_square_stage.sv | 24 ++
 rtl/mean_square_accumulator_v1_0.sv | 60 ++++++
 3 files changed

// File: rtl/mean_square_accumulator_v1_0_pkg.sv
// mean_square_accumulator_v1_0_pkg: shared widths and output FSM states
package mean_square_accumulator_v1_0_pkg;
  typedef enum logic {IDLE, PULSE} state_t;
  function automatic int res_width(input int w);
    return 2 * w;
  endfunction
  function automatic int acc_width(input int w, input int l);
    return 2 * w + l;
  endfunction
endpackage

// File: rtl/signed_square_stage.sv
// signed_square_stage: registered square of a signed sample with valid
module signed_square_stage
  import mean_square_accumulator_v1_0_pkg::*;
#(
  parameter int inout_width = 16
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic signed [inout_width-1:0]       sample,
  input  logic                                in_valid,
  output logic [res_width(inout_width)-1:0]   square,
  output logic                                out_valid
);
  logic signed [res_width(inout_width)-1:0] ext;
  assign ext = {{inout_width{sample[inout_width-1]}}, sample};
  always_ff @(posedge aclk)
    if (!resetn) begin
      square    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) square <= $unsigned(ext * ext);
    end
endmodule

// File: rtl/mean_square_accumulator_v1_0.sv
// mean_square_accumulator_v1_0: windowed mean of squared samples with
// a one-cycle valid pulse towards the sqrt stage
module mean_square_accumulator_v1_0
  import mean_square_accumulator_v1_0_pkg::*;
#(
  parameter int inout_width = 16,
  parameter int window_log2 = 8
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic signed [inout_width-1:0] sample,
  input  logic                          s_data_valid,
  output logic [2*inout_width-1:0]      mean_square,
  output logic                          m_data_valid,
  input  logic                          m_data_ready,
  output logic                          overrun
);
  localparam int RW = res_width(inout_width);
  localparam int AW = acc_width(inout_width, window_log2);
  logic [RW-1:0] square;
  logic sq_valid;
  logic [AW-1:0] acc, sum;
  logic [window_log2-1:0] count;
  logic pending, close, clear;
  state_t state;
  signed_square_stage #(.inout_width(inout_width)) u_square (
    .aclk      (aclk),
    .resetn    (resetn),
    .sample    (sample),
    .in_valid  (s_data_valid),
    .square    (square),
    .out_valid (sq_valid)
  );
  always_comb begin
    sum   = acc + AW'(square);
    close = sq_valid && (&count);
    clear = (state == IDLE) && pending && m_data_ready;
  end
  // a close in the same cycle as the hand-off re-arms pending without overrun
  always_ff @(posedge aclk)
    if (!resetn) begin
      acc          <= '0;
      count        <= '0;
      mean_square  <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      m_data_valid <= 1'b0;
      state        <= IDLE;
    end else begin
      if (sq_valid) begin
        acc   <= close ? '0 : sum;
        count <= count + window_log2'(1);
      end
      if (close) mean_square <= sum[window_log2 +: RW];
      pending      <= close || (pending && !clear);
      overrun      <= overrun || (close && pending && !clear);
      state        <= clear ? PULSE : IDLE;
      m_data_valid <= clear;
    end
endmodule
